// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared types and helpers for the digit-serial adder
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/digit_adder.sv
// rtl/digit_adder.sv - DIGIT-bit ripple adder; also exposes the carry into its top bit
module digit_adder #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             ctop
);

    logic [DIGIT:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < DIGIT; i++) begin : g_bit
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i]),
            .sum  (sum[i]),
            .cout (c[i+1])
        );
    end

    assign cout = c[DIGIT];
    // carry into the top bit; for DIGIT=1 this is simply cin
    assign ctop = c[DIGIT-1];

endmodule

// File: rtl/full_adder.sv
// rtl/full_adder.sv - one-bit full adder cell
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - digit-serial add (subtract with SERIAL_ADDER_SUB_EN) with valid/ready handshake
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             op,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             V,
    output logic             busy
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (clog2(NDIG) < 1) ? 1 : clog2(NDIG);

    if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
        $error("serial_adder: illegal WIDTH/DIGIT combination");
    end

    state_t            state, state_next;
    logic [WIDTH-1:0]  a_q, b_q;
    logic              carry;
    logic [CW-1:0]     cnt;
    logic              last;
    logic              op_in;
    logic [DIGIT-1:0]  dsum;
    logic              dcout, dtop;

`ifdef SERIAL_ADDER_SUB_EN
    assign op_in = op;
`else
    assign op_in = OP_ADD;
`endif

    assign last = (cnt == CW'(NDIG - 1));

    digit_adder #(.DIGIT(DIGIT)) u_digit (
        .a    (a_q[cnt*DIGIT +: DIGIT]),
        .b    (b_q[cnt*DIGIT +: DIGIT]),
        .cin  (carry),
        .sum  (dsum),
        .cout (dcout),
        .ctop (dtop)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last) state_next = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // subtraction is folded into the accept: A - B - Cin == A + ~B + ~Cin
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            S     <= '0;
            Cout  <= 1'b0;
            V     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= A;
                        b_q   <= (op_in == OP_SUB) ? ~B : B;
                        carry <= (op_in == OP_SUB) ? ~Cin : Cin;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    S[cnt*DIGIT +: DIGIT] <= dsum;
                    carry <= dcout;
                    cnt   <= cnt + 1'b1;
                    if (last) begin
                        Cout <= dcout;
                        V    <= dcout ^ dtop;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed self-checking bench for serial_adder (DIGIT=2 and DIGIT=1 instances)
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] A, B;
    logic       Cin;
    logic       op;
    logic       out_ready;
    logic       in_valid1, in_valid2;
    logic       in_ready1, in_ready2;
    logic       out_valid1, out_valid2;
    logic [7:0] s1, s2;
    logic       cout1, cout2, v1, v2, busy1, busy2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8), .DIGIT(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .A(A), .B(B), .Cin(Cin),
`ifdef SERIAL_ADDER_SUB_EN
        .op(op),
`endif
        .out_valid(out_valid1), .out_ready(out_ready),
        .S(s1), .Cout(cout1), .V(v1), .busy(busy1)
    );

    serial_adder #(.WIDTH(8), .DIGIT(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
        .A(A), .B(B), .Cin(Cin),
`ifdef SERIAL_ADDER_SUB_EN
        .op(op),
`endif
        .out_valid(out_valid2), .out_ready(out_ready),
        .S(s2), .Cout(cout2), .V(v2), .busy(busy2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input int sel, input logic [7:0] a, input logic [7:0] b,
                          input logic cin, input logic opv, input logic [7:0] es,
                          input logic ec, input logic ev, input int lat, input string tag);
        int  n;
        logic ov;
        @(negedge clk);
        A = a; B = b; Cin = cin; op = opv; out_ready = 1'b0;
        if (sel == 0) in_valid1 = 1'b1; else in_valid2 = 1'b1;
        @(posedge clk); #1;
        in_valid1 = 1'b0; in_valid2 = 1'b0;
        n = 0; ov = 1'b0;
        while (!ov && n < 40) begin
            @(posedge clk); #1;
            n++;
            ov = (sel == 0) ? out_valid1 : out_valid2;
        end
        check({tag, "_latency"}, n, lat);
        check({tag, "_S"},    (sel == 0) ? s1 : s2, es);
        check({tag, "_Cout"}, (sel == 0) ? cout1 : cout2, ec);
        check({tag, "_V"},    (sel == 0) ? v1 : v2, ev);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, "_ov_low"}, (sel == 0) ? out_valid1 : out_valid2, 0);
        check({tag, "_in_ready"}, (sel == 0) ? in_ready1 : in_ready2, 1);
        out_ready = 1'b0;
    endtask

    initial begin
        int seen;
        rst = 1'b1; A = '0; B = '0; Cin = 1'b0; op = 1'b0;
        out_ready = 1'b0; in_valid1 = 1'b0; in_valid2 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_S", s1, 0);
        check("rst_out_valid", out_valid1, 0);
        check("rst_busy", busy1, 0);
        check("rst_in_ready", in_ready1, 1);
        @(negedge clk) rst = 1'b0;

        run_op(0, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 4, "ovf");
        run_op(0, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 4, "wrap1");
        run_op(0, 8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 4, "wrap2");

        // backpressure, with in_valid held high and junk operands while busy
        @(negedge clk);
        A = 8'h3C; B = 8'h0F; Cin = 1'b1; in_valid1 = 1'b1;
        @(posedge clk); #1;
        A = 8'hFF; B = 8'hFF; Cin = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("bp_valid", out_valid1, 1);
        check("bp_S", s1, 8'h4C);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_hold_valid", out_valid1, 1);
            check("bp_hold_S", s1, 8'h4C);
            check("bp_hold_CV", {cout1, v1}, 2'b00);
            check("bp_in_ready", in_ready1, 0);
        end
        @(negedge clk);
        in_valid1 = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", out_valid1, 0);
        check("bp_release_ready", in_ready1, 1);
        check("bp_retain_S", s1, 8'h4C);
        out_ready = 1'b0;

        // reset two edges into RUN
        @(negedge clk);
        A = 8'h12; B = 8'h34; Cin = 1'b0; in_valid1 = 1'b1;
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_S", s1, 0);
        check("mid_rst_CV", {cout1, v1}, 2'b00);
        check("mid_rst_valid", out_valid1, 0);
        check("mid_rst_busy", busy1, 0);
        @(negedge clk) rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid1) seen++;
        end
        check("mid_rst_no_result", seen, 0);
        run_op(0, 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0, 4, "after_rst");

        run_op(1, 8'hAA, 8'h55, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8, "d1_sum");
        run_op(1, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 8, "d1_ovf");

`ifdef SERIAL_ADDER_SUB_EN
        run_op(0, 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, 4, "sub1");
        run_op(0, 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 4, "sub2");
        run_op(1, 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 8, "d1_sub");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
